regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
- Sequences the 6502 register file's single write port (dataIn/regSelect/load) for register-transfer, increment/decrement, load-immediate and PC-increment micro-ops.
- Each accepted command becomes 0-2 ordered register-file writes, including the N/Z flag write-back to PSR.
- Sits between the instruction decoder (command side) and the register file; it reads the register file's parallel outputs.

Parameters:
- PSR_N_BIT, 7, PSR bit position of the Negative flag.
- PSR_Z_BIT, 1, PSR bit position of the Zero flag.
- FLAG_UPDATE_EN, 1, 1 = flag-affecting ops perform the PSR write; 0 = PSR write is skipped.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE with reset low; a command is accepted when valid&ready.
- cmd_op  input  4  micro-op code (below).
- cmd_data  input  8  immediate operand for LDA/LDX/LDY.
- rf_Acc, rf_X, rf_Y, rf_SP, rf_PSR  input  8 each  register file outputs.
- rf_PC  input  16  register file PC output.
- rf_dataIn  output  8  write data to register file.
- rf_regSelect  output  3  register select: 0 Acc, 1 X, 2 Y, 3 SP, 4 PCL, 5 PCH, 6 PSR.
- rf_load  output  1  write strobe; the register file captures at the rising edge ending the cycle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a command completes.
- illegal  output  1  one-cycle pulse, coincident with done, for op 4'hF.

Behaviour:
- Op codes:
  - 0 NOP.
  - 1 TAX, 2 TXA, 3 TAY, 4 TYA, 5 TSX.
  - 6 TXS (no flags).
  - 7 INX, 8 DEX, 9 INY, A DEY (8-bit wrap).
  - B INC_PC.
  - C LDA#, D LDX#, E LDY# (load cmd_data).
  - F illegal.
- All ops except NOP, TXS, INC_PC and F update flags.
- States: IDLE, WR_DST, WR_PSR, WR_PCH.
- Accept cycle T (IDLE):
  - Latch destination select, 8-bit result, and N = result[7], Z = (result == 0), all computed from rf_* values sampled in cycle T.
  - For INC_PC, latch carry = (rf_PC[7:0] == 8'hFF).
- IDLE transitions:
  - NOP or F: stay in IDLE; done=1 in T+1 (illegal=1 also for F); no writes.
  - Any other op: go to WR_DST.
- WR_DST (T+1): rf_load=1, rf_regSelect=dest, rf_dataIn=result. Next state:
  - Flag op with FLAG_UPDATE_EN=1: WR_PSR.
  - INC_PC with carry: WR_PCH.
  - Otherwise: IDLE, with done=1 in that IDLE cycle.
- WR_PSR (T+2): rf_load=1, rf_regSelect=6, rf_dataIn = rf_PSR as sampled this cycle with bit PSR_N_BIT replaced by N and bit PSR_Z_BIT replaced by Z. Next: IDLE, done=1.
- WR_PCH (T+2): rf_load=1, rf_regSelect=5, rf_dataIn = rf_PC[15:8]+1 (so PC 16'hFFFF wraps to 16'h0000). Next: IDLE, done=1.
- Outputs:
  - rf_load, rf_regSelect and rf_dataIn are registered and valid for exactly the write state's cycle.
  - rf_load=0 and rf_dataIn=0 in every other cycle.
- Write ordering is always destination first, then PSR or PCH.
- done is asserted in the first IDLE cycle after the last write, and cmd_ready=1 in that same cycle, so back-to-back commands are allowed.
- Total latency, accept to done:
  - 1 cycle: NOP, F.
  - 2 cycles: single write.
  - 3 cycles: two writes.
- cmd_op and cmd_data are ignored when not accepted. cmd_valid while busy is held off by cmd_ready=0; commands are never queued.
- Reset (at any time, including mid-sequence):
  - Next edge: state=IDLE, rf_load=0, rf_regSelect=0, rf_dataIn=0, done=0, illegal=0, busy=0, latched carry/result cleared.
  - An in-progress command is abandoned: no further writes and no done.
  - cmd_ready=0 while reset is high.

Test Plan:
- Reset mid-INX: reset=1 during WR_DST → next cycle rf_load=0, busy=0, no WR_PSR, no done; cmd_ready=1 after reset drops.
- TAX with Acc=8'h80, PSR=8'h22 → T+1: load, sel=1, data=8'h80; T+2: sel=6, data=8'hA0; T+3: done=1, cmd_ready=1.
- DEX with X=8'h00 → sel=1, data=8'hFF, then PSR N=1, Z=0. INY with Y=8'hFF → data=8'h00, then PSR Z=1, N=0.
- INC_PC:
  - PC=16'h12FF → sel=4 data=8'h00, then sel=5 data=8'h13, then done.
  - PC=16'h1234 → single write sel=4 data=8'h35, done at T+2.
  - PC=16'hFFFF → writes 8'h00 then 8'h00.
- TXS with X=8'hFD → single write sel=3 data=8'hFD, no PSR write, done at T+2. LDA# cmd_data=8'h00 → sel=0 data=0, then PSR Z=1.
- Op F, then NOP, then TYA held valid back-to-back:
  - F: done and illegal at T+1, no load.
  - NOP: done at T+2, no load.
  - TYA: accepted in the same cycle each prior done is high; cmd_ready=0 throughout TYA's write states.

Source files
------------

// File: rtl/regfile_sequencer_if.sv
// Command and register-file bus between the instruction decoder, the
// sequencer and the 6502 register file.
interface regfile_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_data;

    logic [7:0]  rf_Acc;
    logic [7:0]  rf_X;
    logic [7:0]  rf_Y;
    logic [7:0]  rf_SP;
    logic [7:0]  rf_PSR;
    logic [15:0] rf_PC;

    logic [7:0]  rf_dataIn;
    logic [2:0]  rf_regSelect;
    logic        rf_load;

    logic        busy;
    logic        done;
    logic        illegal;

    // decoder / register-file side
    modport master (
        output cmd_valid, cmd_op, cmd_data,
        output rf_Acc, rf_X, rf_Y, rf_SP, rf_PSR, rf_PC,
        input  cmd_ready, rf_dataIn, rf_regSelect, rf_load,
        input  busy, done, illegal
    );

    // sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        input  rf_Acc, rf_X, rf_Y, rf_SP, rf_PSR, rf_PC,
        output cmd_ready, rf_dataIn, rf_regSelect, rf_load,
        output busy, done, illegal
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Turns one decoded micro-op into 0-2 ordered writes on the register file's
// single write port, including the N/Z write-back to PSR.
//
//   state  | meaning
//   IDLE   | ready for a command; done pulses here after the last write
//   WR_DST | destination register write (Acc/X/Y/SP/PCL)
//   WR_PSR | PSR write with N/Z replaced
//   WR_PCH | PCH increment after a PCL carry-out
module regfile_sequencer #(
    parameter int PSR_N_BIT      = 7,
    parameter int PSR_Z_BIT      = 1,
    parameter bit FLAG_UPDATE_EN = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    regfile_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_DST = 2'd1,
        WR_PSR = 2'd2,
        WR_PCH = 2'd3
    } state_t;

    localparam logic [2:0] SEL_ACC = 3'd0;
    localparam logic [2:0] SEL_X   = 3'd1;
    localparam logic [2:0] SEL_Y   = 3'd2;
    localparam logic [2:0] SEL_SP  = 3'd3;
    localparam logic [2:0] SEL_PCL = 3'd4;
    localparam logic [2:0] SEL_PCH = 3'd5;
    localparam logic [2:0] SEL_PSR = 3'd6;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_TAX    = 4'h1;
    localparam logic [3:0] OP_TXA    = 4'h2;
    localparam logic [3:0] OP_TAY    = 4'h3;
    localparam logic [3:0] OP_TYA    = 4'h4;
    localparam logic [3:0] OP_TSX    = 4'h5;
    localparam logic [3:0] OP_TXS    = 4'h6;
    localparam logic [3:0] OP_INX    = 4'h7;
    localparam logic [3:0] OP_DEX    = 4'h8;
    localparam logic [3:0] OP_INY    = 4'h9;
    localparam logic [3:0] OP_DEY    = 4'hA;
    localparam logic [3:0] OP_INC_PC = 4'hB;
    localparam logic [3:0] OP_LDA    = 4'hC;
    localparam logic [3:0] OP_LDX    = 4'hD;
    localparam logic [3:0] OP_LDY    = 4'hE;
    localparam logic [3:0] OP_ILL    = 4'hF;

    state_t      state;
    logic [7:0]  data_q;
    logic [2:0]  sel_q;
    logic        load_q;
    logic        done_q;
    logic        illegal_q;
    logic        n_q;
    logic        z_q;
    logic        flag_q;
    logic        carry_q;

    logic [2:0]  dst_d;
    logic [7:0]  res_d;
    logic        flag_d;
    logic [7:0]  psr_wr;
    logic [7:0]  pch_inc;

    // Destination, result and whether the op touches N/Z, all from this cycle's rf_* values.
    always_comb begin
        dst_d  = SEL_ACC;
        res_d  = 8'h00;
        flag_d = 1'b1;
        case (bus.cmd_op)
            OP_TAX:    begin dst_d = SEL_X;   res_d = bus.rf_Acc; end
            OP_TXA:    begin dst_d = SEL_ACC; res_d = bus.rf_X;   end
            OP_TAY:    begin dst_d = SEL_Y;   res_d = bus.rf_Acc; end
            OP_TYA:    begin dst_d = SEL_ACC; res_d = bus.rf_Y;   end
            OP_TSX:    begin dst_d = SEL_X;   res_d = bus.rf_SP;  end
            OP_TXS:    begin dst_d = SEL_SP;  res_d = bus.rf_X;   flag_d = 1'b0; end
            OP_INX:    begin dst_d = SEL_X;   res_d = bus.rf_X + 8'd1; end
            OP_DEX:    begin dst_d = SEL_X;   res_d = bus.rf_X - 8'd1; end
            OP_INY:    begin dst_d = SEL_Y;   res_d = bus.rf_Y + 8'd1; end
            OP_DEY:    begin dst_d = SEL_Y;   res_d = bus.rf_Y - 8'd1; end
            OP_INC_PC: begin dst_d = SEL_PCL; res_d = bus.rf_PC[7:0] + 8'd1; flag_d = 1'b0; end
            OP_LDA:    begin dst_d = SEL_ACC; res_d = bus.cmd_data; end
            OP_LDX:    begin dst_d = SEL_X;   res_d = bus.cmd_data; end
            OP_LDY:    begin dst_d = SEL_Y;   res_d = bus.cmd_data; end
            default:   flag_d = 1'b0;
        endcase
    end

    // PSR and PCH are never the destination write, so sampling them during
    // WR_DST sees the same value they hold in the following write cycle.
    always_comb begin
        psr_wr            = bus.rf_PSR;
        psr_wr[PSR_N_BIT] = n_q;
        psr_wr[PSR_Z_BIT] = z_q;
    end

    assign pch_inc = bus.rf_PC[15:8] + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            load_q    <= 1'b0;
            sel_q     <= 3'd0;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
            flag_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            load_q    <= 1'b0;
            sel_q     <= 3'd0;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_op == OP_NOP || bus.cmd_op == OP_ILL) begin
                            done_q    <= 1'b1;
                            illegal_q <= (bus.cmd_op == OP_ILL);
                        end else begin
                            state   <= WR_DST;
                            load_q  <= 1'b1;
                            sel_q   <= dst_d;
                            data_q  <= res_d;
                            n_q     <= res_d[7];
                            z_q     <= (res_d == 8'h00);
                            flag_q  <= flag_d;
                            carry_q <= (bus.cmd_op == OP_INC_PC) && (bus.rf_PC[7:0] == 8'hFF);
                        end
                    end
                end
                WR_DST: begin
                    if (flag_q && FLAG_UPDATE_EN) begin
                        state  <= WR_PSR;
                        load_q <= 1'b1;
                        sel_q  <= SEL_PSR;
                        data_q <= psr_wr;
                    end else if (carry_q) begin
                        state  <= WR_PCH;
                        load_q <= 1'b1;
                        sel_q  <= SEL_PCH;
                        data_q <= pch_inc;
                    end else begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                WR_PSR, WR_PCH: begin
                    state   <= IDLE;
                    done_q  <= 1'b1;
                    carry_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = (state == IDLE) && !reset;
    assign bus.busy         = (state != IDLE);
    assign bus.rf_load      = load_q;
    assign bus.rf_regSelect = sel_q;
    assign bus.rf_dataIn    = data_q;
    assign bus.done         = done_q;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a register-file model captures the DUT's writes,
// and an op-level reference model predicts the per-cycle bus activity.
module tb_regfile_sequencer;
    localparam bit FLAG_EN = 1'b1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_sequencer_if bus ();

    regfile_sequencer #(
        .PSR_N_BIT      (7),
        .PSR_Z_BIT      (1),
        .FLAG_UPDATE_EN (FLAG_EN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] bank [0:6];
    logic [7:0] mreg [0:6];

    assign bus.rf_Acc = bank[0];
    assign bus.rf_X   = bank[1];
    assign bus.rf_Y   = bank[2];
    assign bus.rf_SP  = bank[3];
    assign bus.rf_PC  = {bank[5], bank[4]};
    assign bus.rf_PSR = bank[6];

    logic [3:0] s_op  [$];
    logic [7:0] s_dat [$];
    logic [2:0] w_sel [$];
    logic [7:0] w_dat [$];
    logic       m_ill;
    logic [2:0] obs_sel  [$];
    logic [7:0] obs_dat  [$];
    int         obs_done [$];

    bit         e_load  [0:63];
    logic [2:0] e_sel   [0:63];
    logic [7:0] e_dat   [0:63];
    bit         e_done  [0:63];
    bit         e_ill   [0:63];
    bit         e_ready [0:63];

    // Op-level model: the writes one command produces, applied to mreg in order.
    task automatic model_cmd(input logic [3:0] op, input logic [7:0] d);
        logic [7:0]  res;
        logic [15:0] pc;
        logic [7:0]  psr;
        int          dst;
        bit          flag;
        w_sel.delete();
        w_dat.delete();
        m_ill = 1'b0;
        dst   = -1;
        flag  = 1'b1;
        res   = 8'h00;
        case (op)
            4'h0: flag = 1'b0;
            4'h1: begin dst = 1; res = mreg[0]; end
            4'h2: begin dst = 0; res = mreg[1]; end
            4'h3: begin dst = 2; res = mreg[0]; end
            4'h4: begin dst = 0; res = mreg[2]; end
            4'h5: begin dst = 1; res = mreg[3]; end
            4'h6: begin dst = 3; res = mreg[1]; flag = 1'b0; end
            4'h7: begin dst = 1; res = mreg[1] + 8'd1; end
            4'h8: begin dst = 1; res = mreg[1] - 8'd1; end
            4'h9: begin dst = 2; res = mreg[2] + 8'd1; end
            4'hA: begin dst = 2; res = mreg[2] - 8'd1; end
            4'hB: begin
                flag = 1'b0;
                pc   = {mreg[5], mreg[4]} + 16'd1;
                w_sel.push_back(3'd4);
                w_dat.push_back(pc[7:0]);
                if (pc[15:8] != mreg[5]) begin
                    w_sel.push_back(3'd5);
                    w_dat.push_back(pc[15:8]);
                end
            end
            4'hC: begin dst = 0; res = d; end
            4'hD: begin dst = 1; res = d; end
            4'hE: begin dst = 2; res = d; end
            default: begin flag = 1'b0; m_ill = 1'b1; end
        endcase
        if (dst >= 0) begin
            w_sel.push_back(3'(dst));
            w_dat.push_back(res);
        end
        if (flag && FLAG_EN) begin
            psr    = mreg[6];
            psr[7] = res[7];
            psr[1] = (res == 8'h00);
            w_sel.push_back(3'd6);
            w_dat.push_back(psr);
        end
        foreach (w_sel[j]) mreg[w_sel[j]] = w_dat[j];
    endtask

    // Holds cmd_valid high over the whole command list and checks every cycle.
    task automatic run_stream();
        int t;
        int n;
        int last;
        int head;
        int acc [$];
        bit p_ld;
        logic [2:0] p_sel;
        logic [7:0] p_dat;
        for (int k = 0; k < 64; k++) begin
            e_load[k] = 1'b0; e_sel[k] = 3'd0; e_dat[k] = 8'h00;
            e_done[k] = 1'b0; e_ill[k] = 1'b0; e_ready[k] = 1'b1;
        end
        for (int i = 0; i < 7; i++) mreg[i] = bank[i];
        obs_sel.delete();
        obs_dat.delete();
        obs_done.delete();
        t = 0;
        foreach (s_op[i]) begin
            model_cmd(s_op[i], s_dat[i]);
            acc.push_back(t);
            foreach (w_sel[j]) begin
                e_load[t+1+j]  = 1'b1;
                e_sel[t+1+j]   = w_sel[j];
                e_dat[t+1+j]   = w_dat[j];
                e_ready[t+1+j] = 1'b0;
            end
            n = w_sel.size();
            e_done[t+n+1] = 1'b1;
            e_ill[t+n+1]  = m_ill;
            t = t + n + 1;
        end
        last = t + 1;
        head = 0;
        for (int k = 0; k <= last; k++) begin
            while (head < acc.size() && acc[head] < k) head++;
            if (head < s_op.size()) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = s_op[head];
                bus.cmd_data  = s_dat[head];
            end else begin
                bus.cmd_valid = 1'b0;
                bus.cmd_op    = 4'($urandom);
                bus.cmd_data  = 8'($urandom);
            end
            @(negedge clk);
            vectors++;
            if (bus.rf_load !== e_load[k])
                begin miscompares++; $display("FAIL rf_load cycle %0d: got %b expected %b", k, bus.rf_load, e_load[k]); end
            vectors++;
            if (bus.done !== e_done[k])
                begin miscompares++; $display("FAIL done cycle %0d: got %b expected %b", k, bus.done, e_done[k]); end
            vectors++;
            if (bus.illegal !== e_ill[k])
                begin miscompares++; $display("FAIL illegal cycle %0d: got %b expected %b", k, bus.illegal, e_ill[k]); end
            vectors++;
            if (bus.cmd_ready !== e_ready[k])
                begin miscompares++; $display("FAIL cmd_ready cycle %0d: got %b expected %b", k, bus.cmd_ready, e_ready[k]); end
            vectors++;
            if (bus.busy !== !e_ready[k])
                begin miscompares++; $display("FAIL busy cycle %0d: got %b expected %b", k, bus.busy, !e_ready[k]); end
            if (e_load[k]) begin
                vectors++;
                if (bus.rf_regSelect !== e_sel[k])
                    begin miscompares++; $display("FAIL rf_regSelect cycle %0d: got %0d expected %0d", k, bus.rf_regSelect, e_sel[k]); end
            end
            vectors++;
            if (bus.rf_dataIn !== e_dat[k])
                begin miscompares++; $display("FAIL rf_dataIn cycle %0d: got %h expected %h", k, bus.rf_dataIn, e_dat[k]); end
            p_ld  = bus.rf_load;
            p_sel = bus.rf_regSelect;
            p_dat = bus.rf_dataIn;
            if (p_ld) begin obs_sel.push_back(p_sel); obs_dat.push_back(p_dat); end
            if (bus.done) obs_done.push_back(k);
            @(posedge clk);
            #1;
            if (p_ld && p_sel <= 3'd6) bank[p_sel] = p_dat;
        end
        bus.cmd_valid = 1'b0;
        s_op.delete();
        s_dat.delete();
    endtask

    task automatic randomize_bank();
        for (int i = 0; i < 7; i++) bank[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'h7;
        bus.cmd_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.rf_load !== 1'b0 || bus.rf_dataIn !== 8'h00 || bus.rf_regSelect !== 3'd0)
            begin miscompares++; $display("FAIL reset_outputs: got load=%b sel=%0d data=%h expected 0/0/00", bus.rf_load, bus.rf_regSelect, bus.rf_dataIn); end
        vectors++;
        if (bus.done !== 1'b0 || bus.illegal !== 1'b0 || bus.busy !== 1'b0)
            begin miscompares++; $display("FAIL reset_status: got done=%b illegal=%b busy=%b expected 0/0/0", bus.done, bus.illegal, bus.busy); end
        vectors++;
        if (bus.cmd_ready !== 1'b0)
            begin miscompares++; $display("FAIL reset_ready: got %b expected 0", bus.cmd_ready); end
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.cmd_ready !== 1'b1)
            begin miscompares++; $display("FAIL ready_after_reset: got %b expected 1", bus.cmd_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_transfer();
        randomize_bank();
        bank[0] = 8'h80;
        bank[6] = 8'h22;
        s_op.push_back(4'h1); s_dat.push_back(8'h5A);
        run_stream();
        vectors++;
        if (obs_sel.size() != 2 || obs_sel[0] !== 3'd1 || obs_dat[0] !== 8'h80)
            begin miscompares++; $display("FAIL tax_dest: got n=%0d sel=%0d data=%h expected 2 writes, 1/80", obs_sel.size(), obs_sel[0], obs_dat[0]); end
        vectors++;
        if (obs_sel[1] !== 3'd6 || obs_dat[1] !== 8'hA0)
            begin miscompares++; $display("FAIL tax_psr: got sel=%0d data=%h expected 6/a0", obs_sel[1], obs_dat[1]); end
        vectors++;
        if (obs_done.size() != 1 || obs_done[0] != 3)
            begin miscompares++; $display("FAIL tax_latency: got done at %0d expected 3", obs_done[0]); end
    endtask

    task automatic test_incdec();
        randomize_bank();
        bank[1] = 8'h00;
        s_op.push_back(4'h8); s_dat.push_back(8'h00);
        run_stream();
        vectors++;
        if (obs_dat[0] !== 8'hFF || obs_dat[1][7] !== 1'b1 || obs_dat[1][1] !== 1'b0)
            begin miscompares++; $display("FAIL dex_wrap: got data=%h psr=%h expected ff, N=1 Z=0", obs_dat[0], obs_dat[1]); end
        randomize_bank();
        bank[2] = 8'hFF;
        s_op.push_back(4'h9); s_dat.push_back(8'h00);
        run_stream();
        vectors++;
        if (obs_dat[0] !== 8'h00 || obs_dat[1][7] !== 1'b0 || obs_dat[1][1] !== 1'b1)
            begin miscompares++; $display("FAIL iny_wrap: got data=%h psr=%h expected 00, N=0 Z=1", obs_dat[0], obs_dat[1]); end
    endtask

    task automatic test_inc_pc();
        logic [15:0] pcs   [3] = '{16'h12FF, 16'h1234, 16'hFFFF};
        int          nwr   [3] = '{2, 1, 2};
        logic [7:0]  pcl   [3] = '{8'h00, 8'h35, 8'h00};
        logic [7:0]  pch   [3] = '{8'h13, 8'h00, 8'h00};
        int          dcyc  [3] = '{3, 2, 3};
        for (int i = 0; i < 3; i++) begin
            randomize_bank();
            bank[4] = pcs[i][7:0];
            bank[5] = pcs[i][15:8];
            s_op.push_back(4'hB); s_dat.push_back(8'($urandom));
            run_stream();
            vectors++;
            if (obs_sel.size() != nwr[i] || obs_sel[0] !== 3'd4 || obs_dat[0] !== pcl[i])
                begin miscompares++; $display("FAIL inc_pc_low pc=%h: got n=%0d sel=%0d data=%h expected %0d/4/%h", pcs[i], obs_sel.size(), obs_sel[0], obs_dat[0], nwr[i], pcl[i]); end
            if (nwr[i] == 2) begin
                vectors++;
                if (obs_sel[1] !== 3'd5 || obs_dat[1] !== pch[i])
                    begin miscompares++; $display("FAIL inc_pc_high pc=%h: got sel=%0d data=%h expected 5/%h", pcs[i], obs_sel[1], obs_dat[1], pch[i]); end
            end
            vectors++;
            if (obs_done[0] != dcyc[i])
                begin miscompares++; $display("FAIL inc_pc_latency pc=%h: got %0d expected %0d", pcs[i], obs_done[0], dcyc[i]); end
        end
    endtask

    task automatic test_txs_lda();
        randomize_bank();
        bank[1] = 8'hFD;
        s_op.push_back(4'h6); s_dat.push_back(8'h00);
        run_stream();
        vectors++;
        if (obs_sel.size() != 1 || obs_sel[0] !== 3'd3 || obs_dat[0] !== 8'hFD || obs_done[0] != 2)
            begin miscompares++; $display("FAIL txs: got n=%0d sel=%0d data=%h done=%0d expected 1/3/fd/2", obs_sel.size(), obs_sel[0], obs_dat[0], obs_done[0]); end
        randomize_bank();
        s_op.push_back(4'hC); s_dat.push_back(8'h00);
        run_stream();
        vectors++;
        if (obs_sel[0] !== 3'd0 || obs_dat[0] !== 8'h00 || obs_sel[1] !== 3'd6 || obs_dat[1][1] !== 1'b1)
            begin miscompares++; $display("FAIL lda_zero: got sel=%0d data=%h psr=%h expected 0/00 then Z=1", obs_sel[0], obs_dat[0], obs_dat[1]); end
    endtask

    task automatic test_back_to_back();
        randomize_bank();
        s_op.push_back(4'hF); s_dat.push_back(8'($urandom));
        s_op.push_back(4'h0); s_dat.push_back(8'($urandom));
        s_op.push_back(4'h4); s_dat.push_back(8'($urandom));
        run_stream();
        vectors++;
        if (obs_done.size() != 3 || obs_done[0] != 1 || obs_done[1] != 2 || obs_done[2] != 5)
            begin miscompares++; $display("FAIL back_to_back_done: got n=%0d at %0d,%0d,%0d expected 1,2,5", obs_done.size(), obs_done[0], obs_done[1], obs_done[2]); end
        vectors++;
        if (obs_sel.size() != 2 || obs_sel[0] !== 3'd0 || obs_sel[1] !== 3'd6)
            begin miscompares++; $display("FAIL back_to_back_writes: got n=%0d sel=%0d,%0d expected 2 writes 0,6", obs_sel.size(), obs_sel[0], obs_sel[1]); end
    endtask

    task automatic test_reset_mid();
        randomize_bank();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'h7;
        bus.cmd_data  = 8'h00;
        @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b1)
            begin miscompares++; $display("FAIL mid_reset_accept: got ready=%b expected 1", bus.cmd_ready); end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.rf_load !== 1'b1 || bus.cmd_ready !== 1'b0)
            begin miscompares++; $display("FAIL mid_reset_wr_dst: got load=%b ready=%b expected 1/0", bus.rf_load, bus.cmd_ready); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.rf_load !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rf_dataIn !== 8'h00)
                begin miscompares++; $display("FAIL mid_reset_abandon cycle %0d: got load=%b busy=%b done=%b data=%h expected 0/0/0/00", k, bus.rf_load, bus.busy, bus.done, bus.rf_dataIn); end
            vectors++;
            if (bus.cmd_ready !== 1'b1)
                begin miscompares++; $display("FAIL mid_reset_ready cycle %0d: got %b expected 1", k, bus.cmd_ready); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 8; s++) begin
            randomize_bank();
            for (int i = 0; i < 8; i++) begin
                s_op.push_back(4'($urandom_range(0, 15)));
                s_dat.push_back(8'($urandom));
            end
            run_stream();
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'h0;
        bus.cmd_data  = 8'h00;
        for (int i = 0; i < 7; i++) bank[i] = 8'h00;
        test_reset();
        test_transfer();
        test_incdec();
        test_inc_pc();
        test_txs_lda();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
